// File: rtl/cam_types_pkg.sv
// Shared sizes and types for the CAM store.
// Widths here are the defaults picked up by cam_lru_store.
package cam_types_pkg;

    localparam int camsize_p  = 8;
    localparam int keywidth_p = 16;
    localparam int valwidth_p = 16;
    localparam int agew_p     = $clog2(camsize_p);

    typedef logic [keywidth_p-1:0] key_t;
    typedef logic [valwidth_p-1:0] val_t;
    typedef logic [agew_p-1:0]     age_t;

    typedef struct packed {
        logic valid;
        key_t key;
        val_t val;
    } entry_t;

endpackage

// File: rtl/cam_lru_tracker.sv
// True-LRU age array: age 0 is most recent, n_p-1 is the victim.
// Ages stay a permutation of 0..n_p-1.
module cam_lru_tracker #(
    parameter int n_p  = 8,
    parameter int aw_p = $clog2(n_p)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            touch_en,
    input  logic [aw_p-1:0] touch_idx,
    output logic [aw_p-1:0] lru_idx
);

    logic [aw_p-1:0] age_q [n_p];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < n_p; i++) begin
                age_q[i] <= aw_p'(i);
            end
        end else if (touch_en) begin
            for (int i = 0; i < n_p; i++) begin
                if (aw_p'(i) == touch_idx) begin
                    age_q[i] <= '0;
                end else if (age_q[i] < age_q[touch_idx]) begin
                    age_q[i] <= age_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        lru_idx = '0;
        for (int i = 0; i < n_p; i++) begin
            if (age_q[i] == aw_p'(n_p - 1)) begin
                lru_idx = aw_p'(i);
            end
        end
    end

endmodule

// File: rtl/cam_lru_store.sv
// Key/value CAM with registered lookups and true-LRU replacement.
// Writes update in place, fill the lowest free slot, or evict the LRU.
module cam_lru_store #(
    parameter int camsize_p  = cam_types_pkg::camsize_p,
    parameter int keywidth_p = cam_types_pkg::keywidth_p,
    parameter int valwidth_p = cam_types_pkg::valwidth_p
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    input  logic                  rw_n_i,
    input  logic [keywidth_p-1:0] key_i,
    input  logic [valwidth_p-1:0] val_i,
    output logic [valwidth_p-1:0] val_o,
    output logic                  hit_o,
    output logic                  rdone_o
);

    import cam_types_pkg::*;

    localparam int aw_p = $clog2(camsize_p);

    typedef logic [aw_p-1:0] idx_t;

    logic [camsize_p-1:0]  vld_q;
    logic [keywidth_p-1:0] key_q [camsize_p];
    logic [valwidth_p-1:0] val_q [camsize_p];

    logic [camsize_p-1:0] match;
    logic                 hit;
    logic                 free_any;
    logic                 rd;
    logic                 wr;
    logic                 touch_en;
    idx_t                 hit_idx;
    idx_t                 free_idx;
    idx_t                 lru_idx;
    idx_t                 wr_idx;
    idx_t                 touch_idx;

    assign rd = valid_i & rw_n_i;
    assign wr = valid_i & ~rw_n_i;

    // Downward scan so the lowest free index wins.
    always_comb begin
        match    = '0;
        hit      = 1'b0;
        hit_idx  = '0;
        free_any = 1'b0;
        free_idx = '0;
        for (int i = camsize_p - 1; i >= 0; i--) begin
            match[i] = vld_q[i] && (key_q[i] == key_i);
            if (match[i]) begin
                hit     = 1'b1;
                hit_idx = idx_t'(i);
            end
            if (!vld_q[i]) begin
                free_any = 1'b1;
                free_idx = idx_t'(i);
            end
        end
    end

    always_comb begin
        if (hit) begin
            wr_idx = hit_idx;
        end else if (free_any) begin
            wr_idx = free_idx;
        end else begin
            wr_idx = lru_idx;
        end
    end

    assign touch_en  = rd ? hit : wr;
    assign touch_idx = wr ? wr_idx : hit_idx;

    cam_lru_tracker #(
        .n_p  (camsize_p),
        .aw_p (aw_p)
    ) u_lru (
        .clk       (clk),
        .rst_n     (rst_n),
        .touch_en  (touch_en),
        .touch_idx (touch_idx),
        .lru_idx   (lru_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < camsize_p; i++) begin
                key_q[i] <= '0;
                val_q[i] <= '0;
            end
        end else if (wr) begin
            vld_q[wr_idx] <= 1'b1;
            key_q[wr_idx] <= key_i;
            val_q[wr_idx] <= val_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdone_o <= 1'b0;
            hit_o   <= 1'b0;
            val_o   <= '0;
        end else begin
            rdone_o <= rd;
            if (rd) begin
                hit_o <= hit;
                val_o <= hit ? val_q[hit_idx] : '0;
            end
        end
    end

endmodule

// File: tb/tb_cam_lru_store.sv
// Randomized and directed bench for cam_lru_store against a
// recency-queue model of the store.
module tb_cam_lru_store;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0;
    logic        rw_n_i = 1'b1;
    logic [15:0] key_i = '0;
    logic [15:0] val_i = '0;
    logic [15:0] val_o;
    logic        hit_o;
    logic        rdone_o;

    cam_lru_store dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (valid_i),
        .rw_n_i  (rw_n_i),
        .key_i   (key_i),
        .val_i   (val_i),
        .val_o   (val_o),
        .hit_o   (hit_o),
        .rdone_o (rdone_o)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Model: slot contents plus a recency list, most recent at the front.
    bit          m_vld [N];
    logic [15:0] m_key [N];
    logic [15:0] m_val [N];
    int          order [$];
    logic        exp_rdone = 1'b0;
    logic        exp_hit = 1'b0;
    logic [15:0] exp_val = '0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        order = {};
        for (int i = 0; i < N; i++) begin
            m_vld[i] = 1'b0;
            m_key[i] = '0;
            m_val[i] = '0;
            order.push_back(i);
        end
        exp_rdone = 1'b0;
        exp_hit   = 1'b0;
        exp_val   = '0;
    endtask

    function automatic int find(logic [15:0] k);
        for (int i = 0; i < N; i++) begin
            if (m_vld[i] && m_key[i] == k) return i;
        end
        return -1;
    endfunction

    function automatic int occupied();
        int n = 0;
        for (int i = 0; i < N; i++) n += int'(m_vld[i]);
        return n;
    endfunction

    task automatic touch(int e);
        for (int j = 0; j < order.size(); j++) begin
            if (order[j] == e) begin
                order.delete(j);
                break;
            end
        end
        order.push_front(e);
    endtask

    task automatic model_edge(bit v, bit rw, logic [15:0] k, logic [15:0] d);
        int j;
        exp_rdone = 1'b0;
        if (!v) return;
        j = find(k);
        if (rw) begin
            exp_rdone = 1'b1;
            exp_hit   = (j >= 0);
            exp_val   = (j >= 0) ? m_val[j] : 16'h0;
            if (j >= 0) touch(j);
        end else begin
            if (j < 0) begin
                for (int i = 0; i < N; i++) begin
                    if (!m_vld[i]) begin
                        j = i;
                        break;
                    end
                end
            end
            if (j < 0) j = order[$];
            m_vld[j] = 1'b1;
            m_key[j] = k;
            m_val[j] = d;
            touch(j);
        end
    endtask

    // Continuous comparison away from the active edge.
    always @(negedge clk) begin
        check("rdone_o", 32'(rdone_o), 32'(exp_rdone));
        check("hit_o", 32'(hit_o), 32'(exp_hit));
        check("val_o", 32'(val_o), 32'(exp_val));
    end

    task automatic step(bit v, bit rw, logic [15:0] k, logic [15:0] d);
        @(negedge clk);
        valid_i = v;
        rw_n_i  = rw;
        key_i   = k;
        val_i   = d;
        @(posedge clk);
        model_edge(v, rw, k, d);
    endtask

    task automatic wr(logic [15:0] k, logic [15:0] d);
        step(1'b1, 1'b0, k, d);
    endtask

    task automatic rd_expect(string name, logic [15:0] k, bit h, logic [15:0] d);
        step(1'b1, 1'b1, k, 16'h0);
        #1;
        check({name, ".rdone"}, 32'(rdone_o), 32'd1);
        check({name, ".hit"}, 32'(hit_o), 32'(h));
        check({name, ".val"}, 32'(val_o), 32'(d));
    endtask

    task automatic idle();
        step(1'b0, 1'b1, 16'h0, 16'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        valid_i = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst.rdone", 32'(rdone_o), 32'd0);
        check("rst.hit", 32'(hit_o), 32'd0);
        check("rst.val", 32'(val_o), 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #2;
        check("por.rdone", 32'(rdone_o), 32'd0);
        check("por.hit", 32'(hit_o), 32'd0);
        check("por.val", 32'(val_o), 32'd0);
        #20;
        rst_n = 1'b1;

        rd_expect("rd_empty", 16'h1234, 1'b0, 16'h0);
        idle();

        wr(16'h0001, 16'hAAAA);
        rd_expect("rd_aaaa", 16'h0001, 1'b1, 16'hAAAA);
        wr(16'h0001, 16'hBBBB);
        rd_expect("rd_bbbb", 16'h0001, 1'b1, 16'hBBBB);
        check("occupied", 32'(occupied()), 32'd1);
        idle();

        do_reset();
        for (int i = 0; i < 8; i++) wr(16'h10 + 16'(i), 16'h100 + 16'(i));
        rd_expect("rd_10", 16'h0010, 1'b1, 16'h0100);
        wr(16'h0020, 16'h0200);
        rd_expect("evict_11", 16'h0011, 1'b0, 16'h0);
        rd_expect("keep_10", 16'h0010, 1'b1, 16'h0100);
        rd_expect("new_20", 16'h0020, 1'b1, 16'h0200);
        rd_expect("b2b_12", 16'h0012, 1'b1, 16'h0102);
        rd_expect("b2b_99", 16'h0099, 1'b0, 16'h0);
        rd_expect("b2b_13", 16'h0013, 1'b1, 16'h0103);
        idle();

        do_reset();
        for (int i = 0; i < 9; i++) wr(16'h30 + 16'(i), 16'h300 + 16'(i));
        rd_expect("evict_30", 16'h0030, 1'b0, 16'h0);
        for (int i = 1; i < 9; i++) begin
            rd_expect("keep_3x", 16'h30 + 16'(i), 1'b1, 16'h300 + 16'(i));
        end

        // Read in flight when reset lands: its result must vanish.
        step(1'b1, 1'b1, 16'h0031, 16'h0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("mid_rst.rdone", 32'(rdone_o), 32'd0);
        check("mid_rst.hit", 32'(hit_o), 32'd0);
        check("mid_rst.val", 32'(val_o), 32'd0);
        valid_i = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 1; i < 9; i++) begin
            rd_expect("post_rst", 16'h30 + 16'(i), 1'b0, 16'h0);
        end
        idle();

        for (int n = 0; n < 3000; n++) begin
            if (n % 700 == 699) begin
                do_reset();
            end else begin
                step($urandom_range(0, 9) < 8, $urandom_range(0, 1) == 1,
                     16'h40 + 16'($urandom_range(0, 11)), 16'($urandom));
            end
        end
        idle();
        @(negedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/cam_lru_store.md
# cam_lru_store

Content-addressable store that the CAM lab grader observes: holds up to `camsize_p` key/value pairs and answers single-cycle-issued, registered-result lookups by key. Writes to a resident key update it in place. Writes of a new key fill the lowest-index invalid entry, or evict the true least-recently-used entry when full. Instantiated inside the CAM testbench and driven through `cam_if`. Key/value widths and `camsize_p` come from `cam_types_pkg`.

## Interface
- `camsize_p`, default 8 (from `cam_types_pkg`): number of entries; power of two, ≥2.
- `keywidth_p`, default 16: key width.
- `valwidth_p`, default 16: value width.

- `clk`  in  1  sole clock; all state changes on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low; one clock, reset is asynchronous and active-low.
- `valid_i`  in  1  request strobe; one request per cycle when high.
- `rw_n_i`  in  1  1 = read (lookup), 0 = write.
- `key_i`  in  `keywidth_p`  lookup/write key.
- `val_i`  in  `valwidth_p`  write data; ignored on reads.
- `val_o`  out  `valwidth_p`  value from the last read hit; 0 on miss.
- `hit_o`  out  1  last read found `key_i`.
- `rdone_o`  out  1  one-cycle pulse, read result valid this cycle.

## Operation
- Per entry: `valid` bit, key, value, age (`$clog2(camsize_p)` bits); age 0 = MRU, `camsize_p-1` = LRU.
- Reset (async, while `rst_n`=0): all `valid`=0, keys/values=0, age[i]=i, `val_o`=0, `hit_o`=0, `rdone_o`=0.
- Match vector: entry i matches iff `valid[i]` and key[i]==`key_i`. At most one entry may match (invariant; write path guarantees it).
- Read (`valid_i`=1, `rw_n_i`=1):
  - hit: `hit_o`=1, `val_o`=value[j], touch j;
  - miss: `hit_o`=0, `val_o`=0, no age change;
  - `rdone_o`=1 next cycle either way.
- Write (`valid_i`=1, `rw_n_i`=0):
  - hit on j: value[j]=`val_i`, touch j;
  - else lowest-index invalid entry k: fill (valid, key, value), touch k;
  - else victim v = entry with age `camsize_p-1`: overwrite, touch v.
  - `val_o`/`hit_o` unchanged; `rdone_o`=0.
- Touch(e): every entry with age < age[e] increments; age[e]=0; others unchanged. Ages remain a permutation of 0..`camsize_p-1` at all times.
- `valid_i`=0: no state change; `rdone_o`=0; `val_o`/`hit_o` hold.

## Timing
- Write commits on the rising edge where the request is sampled. A read in the next cycle sees it.
- Read latency 1: request sampled at edge N; `val_o`/`hit_o`/`rdone_o` registered at edge N, visible in cycle N+1. `val_o`/`hit_o` hold until the next read.
- Back-to-back requests every cycle: no stalls, no backpressure.
- Write then read of the same key in consecutive cycles returns the new value. Read then write in consecutive cycles: the read returns the pre-write value.
- Reset mid-operation: all state and outputs cleared immediately (asynchronously). An in-flight read produces no `rdone_o`. First request is accepted on the first edge after `rst_n` rises.
- Match and victim selection are combinational, single-cycle. No multi-cycle FSM.

## Structure
- `cam_types_pkg`: `camsize_p`, `key_t`, `val_t`, `age_t` (`logic [$clog2(camsize_p)-1:0]`), `entry_t` struct {valid, key, val}.
- Sub-module `cam_lru_tracker`:
  - inputs: `clk`, `rst_n`, `touch_en`, `touch_idx`;
  - output: `lru_idx`;
  - owns the age array and the touch/reset rules.
- The top owns entry storage, match, fill/victim select, and output registers.

## Test plan
- Reset then read key 0x1234 -> `rdone_o`=1 one cycle later, `hit_o`=0, `val_o`=0.
- Write (0x0001,0xAAAA), next cycle read 0x0001 -> `hit_o`=1, `val_o`=0xAAAA. Write (0x0001,0xBBBB) then read -> 0xBBBB, still one occupied entry.
- Fill 8 keys 0x10..0x17 with values 0x100..0x107, read 0x10, write 0x20 -> 0x11 evicted (read 0x11 misses), 0x10 and 0x20 hit.
- Nine writes 0x30..0x38 with no reads -> 0x30 evicted, 0x31..0x38 hit.
- Back-to-back reads 0x12, 0x99, 0x13 -> `rdone_o` high three consecutive cycles with hit/miss/hit and values 0x102, 0, 0x103.
- Assert `rst_n`=0 mid-stream after filling, between edges -> outputs 0 immediately; after release all earlier keys miss.
